// File: rtl/regfile_8x8_cb_if.sv
// regfile_8x8_cb_if: decode/writeback-side bus of the 8x8 register file with condition bit
interface regfile_8x8_cb_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              write_i;
    logic [ADDR_W-1:0] write_addr_i;
    logic [DATA_W-1:0] write_data_i;
    logic [ADDR_W-1:0] rs_addr_i;
    logic [ADDR_W-1:0] rt_addr_i;
    logic              write_CB_i;
    logic              cb_data_i;
    logic [DATA_W-1:0] rs_data_o;
    logic [DATA_W-1:0] rt_data_o;
    logic              cb_data_o;

    modport master (
        output write_i, write_addr_i, write_data_i, rs_addr_i, rt_addr_i, write_CB_i, cb_data_i,
        input  rs_data_o, rt_data_o, cb_data_o
    );

    modport slave (
        input  write_i, write_addr_i, write_data_i, rs_addr_i, rt_addr_i, write_CB_i, cb_data_i,
        output rs_data_o, rt_data_o, cb_data_o
    );
endinterface

// File: rtl/regfile_8x8_cb.sv
// regfile_8x8_cb: 8x8 register file, two combinational read ports, one write port, condition bit
module regfile_8x8_cb #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    regfile_8x8_cb_if.slave bus
);
    logic [DATA_W-1:0] r_regs [2**ADDR_W];
    logic              r_cb;

    // register storage: async clear, all entries writable including index 0
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 2**ADDR_W; i++) r_regs[i] <= '0;
        end else if (bus.write_i) begin
            r_regs[bus.write_addr_i] <= bus.write_data_i;
        end
    end

    // condition bit, written independently of the register array
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_cb <= 1'b0;
        else if (bus.write_CB_i) r_cb <= bus.cb_data_i;
    end

    assign bus.rs_data_o = r_regs[bus.rs_addr_i];
    assign bus.rt_data_o = r_regs[bus.rt_addr_i];
    assign bus.cb_data_o = r_cb;
endmodule

// File: tb/tb_regfile_8x8_cb.sv
// tb_regfile_8x8_cb: table-driven check of regfile_8x8_cb
module tb_regfile_8x8_cb;
    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    regfile_8x8_cb_if #(.DATA_W(8), .ADDR_W(3)) bus ();

    regfile_8x8_cb #(.DATA_W(8), .ADDR_W(3)) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       we;
        logic [2:0] wa;
        logic [7:0] wd;
        logic [2:0] rs;
        logic [2:0] rt;
        logic       wcb;
        logic       cbd;
        logic [7:0] rs_pre;
        logic [7:0] rt_pre;
        logic [7:0] rs_post;
        logic [7:0] rt_post;
        logic       cb_post;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                         input logic [2:0] rs, input logic [2:0] rt, input logic wcb, input logic cbd);
        bus.write_i      = we;
        bus.write_addr_i = wa;
        bus.write_data_i = wd;
        bus.rs_addr_i    = rs;
        bus.rt_addr_i    = rt;
        bus.write_CB_i   = wcb;
        bus.cb_data_i    = cbd;
    endtask

    initial begin
        logic cb_prev;
        vecs[0] = '{1'b1, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[1] = '{1'b1, 3'd1, 8'h11, 3'd1, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h11, 8'h00, 1'b0};
        vecs[2] = '{1'b1, 3'd2, 8'h22, 3'd0, 3'd2, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h22, 1'b0};
        vecs[3] = '{1'b1, 3'd3, 8'h33, 3'd1, 3'd2, 1'b0, 1'b0, 8'h11, 8'h22, 8'h11, 8'h22, 1'b0};
        vecs[4] = '{1'b1, 3'd1, 8'hA5, 3'd1, 3'd3, 1'b0, 1'b0, 8'h11, 8'h33, 8'hA5, 8'h33, 1'b0};
        vecs[5] = '{1'b0, 3'd7, 8'hFF, 3'd7, 3'd1, 1'b1, 1'b1, 8'h00, 8'hA5, 8'h00, 8'hA5, 1'b1};
        vecs[6] = '{1'b0, 3'd7, 8'hFF, 3'd7, 3'd1, 1'b1, 1'b0, 8'h00, 8'hA5, 8'h00, 8'hA5, 1'b0};
        vecs[7] = '{1'b0, 3'd7, 8'hFF, 3'd7, 3'd1, 1'b0, 1'b1, 8'h00, 8'hA5, 8'h00, 8'hA5, 1'b0};
        vecs[8] = '{1'b1, 3'd7, 8'h77, 3'd7, 3'd7, 1'b1, 1'b1, 8'h00, 8'h00, 8'h77, 8'h77, 1'b1};

        drive(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        // preload some state, then pulse reset mid-cycle and check it clears without an edge
        @(negedge clk_i);
        drive(1'b1, 3'd5, 8'h55, 3'd5, 3'd5, 1'b1, 1'b1);
        @(posedge clk_i); #1;
        chk("preload_rs", bus.rs_data_o, 8'h55);
        chk("preload_cb", {7'd0, bus.cb_data_o}, 8'h01);
        drive(1'b0, 3'd0, 8'h00, 3'd5, 3'd5, 1'b0, 1'b0);
        #1 rst_ni = 1'b0;
        #1;
        chk("async_rst_rs", bus.rs_data_o, 8'h00);
        chk("async_rst_rt", bus.rt_data_o, 8'h00);
        chk("async_rst_cb", {7'd0, bus.cb_data_o}, 8'h00);
        @(negedge clk_i);
        drive(1'b1, 3'd5, 8'hEE, 3'd5, 3'd5, 1'b1, 1'b1);
        @(posedge clk_i); #1;
        chk("rst_write_ignored", bus.rs_data_o, 8'h00);
        chk("rst_cb_ignored", {7'd0, bus.cb_data_o}, 8'h00);
        @(negedge clk_i);
        drive(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0);
        rst_ni = 1'b1;

        cb_prev = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk_i);
            drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].rs, vecs[i].rt, vecs[i].wcb, vecs[i].cbd);
            #1;
            chk($sformatf("v%0d_rs_pre", i), bus.rs_data_o, vecs[i].rs_pre);
            chk($sformatf("v%0d_rt_pre", i), bus.rt_data_o, vecs[i].rt_pre);
            chk($sformatf("v%0d_cb_pre", i), {7'd0, bus.cb_data_o}, {7'd0, cb_prev});
            @(posedge clk_i); #1;
            chk($sformatf("v%0d_rs_post", i), bus.rs_data_o, vecs[i].rs_post);
            chk($sformatf("v%0d_rt_post", i), bus.rt_data_o, vecs[i].rt_post);
            chk($sformatf("v%0d_cb_post", i), {7'd0, bus.cb_data_o}, {7'd0, vecs[i].cb_post});
            cb_prev = vecs[i].cb_post;
        end

        // fill every register with F0+i and read all back through both ports
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            drive(1'b1, 3'(i), 8'hF0 + 8'(i), 3'd0, 3'd0, 1'b0, 1'b0);
        end
        @(negedge clk_i);
        drive(1'b0, 3'd4, 8'h99, 3'd0, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            bus.rs_addr_i = 3'(i);
            bus.rt_addr_i = 3'(7 - i);
            #1;
            chk($sformatf("fill_rs%0d", i), bus.rs_data_o, 8'hF0 + 8'(i));
            chk($sformatf("fill_rt%0d", 7 - i), bus.rt_data_o, 8'hF0 + 8'(7 - i));
        end

        // a cycle with write_i low and fresh data must leave contents unchanged
        bus.rs_addr_i = 3'd4;
        bus.rt_addr_i = 3'd0;
        @(posedge clk_i); #1;
        chk("nowrite_rs4", bus.rs_data_o, 8'hF4);
        chk("nowrite_rt0", bus.rt_data_o, 8'hF0);
        chk("nowrite_cb", {7'd0, bus.cb_data_o}, 8'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
